// File: rtl/volt_window_filter.sv
// volt_window_filter: boxcar moving average of 12-bit ADC samples over 2**LOG2_DEPTH entries.
// Optional macro SPIKE_REJECT_EN replaces outlier samples (|s - V_OUT| > SPIKE_THRESH) once filled.
module volt_window_filter #(
  parameter int LOG2_DEPTH   = 4,
  parameter int SPIKE_THRESH = 512
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CLR,
  input  logic [11:0] SAMPLE_IN,
  input  logic        SAMPLE_VALID,
  output logic [11:0] V_OUT,
  output logic        V_VALID,
  output logic        FILLED,
  output logic [7:0]  SPIKE_CNT
);
  localparam int D = 1 << LOG2_DEPTH;
  localparam int SW = 12 + LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH + 1)'(D);
`ifdef SPIKE_REJECT_EN
  localparam bit SPIKE_ON = 1'b1;
`else
  localparam bit SPIKE_ON = 1'b0;
`endif
  logic [11:0] mem [D];
  logic [LOG2_DEPTH-1:0] wr_ptr;
  logic [SW-1:0] sum, sum_nxt;
  logic [LOG2_DEPTH:0] fill_cnt, fill_nxt;
  logic signed [12:0] diff;
  logic [11:0] mag, s_eff;
  logic spike;
  always_comb begin
    diff = $signed({1'b0, SAMPLE_IN}) - $signed({1'b0, V_OUT});
    mag = diff[12] ? 12'(-diff) : diff[11:0];
    spike = SPIKE_ON && FILLED && (int'(mag) > SPIKE_THRESH);
    s_eff = spike ? V_OUT : SAMPLE_IN;
    // the evicted entry is always part of sum, so this never underflows
    sum_nxt = sum + SW'(s_eff) - SW'(mem[wr_ptr]);
    fill_nxt = (fill_cnt == FULL) ? fill_cnt : fill_cnt + 1'b1;
  end
  assign FILLED = (fill_cnt == FULL);
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      for (int i = 0; i < D; i++) mem[i] <= '0;
      sum      <= '0;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      V_OUT    <= '0;
      V_VALID  <= 1'b0;
    end else begin
      V_VALID <= SAMPLE_VALID && (fill_nxt == FULL);
      if (SAMPLE_VALID) begin
        mem[wr_ptr] <= s_eff;
        sum         <= sum_nxt;
        wr_ptr      <= wr_ptr + 1'b1;
        fill_cnt    <= fill_nxt;
        V_OUT       <= sum_nxt[SW-1:LOG2_DEPTH];
      end
    end
  end
`ifdef SPIKE_REJECT_EN
  logic [7:0] spike_cnt;
  always_ff @(posedge CLK) begin
    if (RST) spike_cnt <= '0;
    else if (!CLR && SAMPLE_VALID && spike && spike_cnt != 8'hff) spike_cnt <= spike_cnt + 1'b1;
  end
  assign SPIKE_CNT = spike_cnt;
`else
  assign SPIKE_CNT = '0;
`endif
endmodule

// File: tb/tb_volt_window_filter.sv
// tb_volt_window_filter: table vectors plus a shifting-window model feeding an expectation queue.
module tb_volt_window_filter;
  typedef struct {
    logic [11:0] vout;
    bit          vv;
    bit          filled;
    logic [7:0]  spk;
  } exp_t;
  typedef struct {
    bit          v;
    bit          c;
    logic [11:0] s;
    exp_t        e;
  } vec_t;
  logic CLK = 1'b0, RST = 1'b0, CLR = 1'b0, SAMPLE_VALID = 1'b0;
  logic [11:0] SAMPLE_IN = '0;
  logic [11:0] V_OUT;
  logic V_VALID, FILLED;
  logic [7:0] SPIKE_CNT;
  int checks = 0, failures = 0, cyc = 0, pulses = 0;
  bit count_en = 1'b0;
  exp_t exp_q[$];
  logic [11:0] win [16];
  int n = 0;
  logic [11:0] m_vout = '0;
  vec_t tbl [64];
  volt_window_filter dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .SAMPLE_IN(SAMPLE_IN), .SAMPLE_VALID(SAMPLE_VALID),
    .V_OUT(V_OUT), .V_VALID(V_VALID), .FILLED(FILLED), .SPIKE_CNT(SPIKE_CNT)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask
  always @(negedge CLK) begin
    exp_t e;
    cyc++;
    if (count_en && V_VALID === 1'b1) pulses++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("v_out@%0d", cyc), 32'(V_OUT), 32'(e.vout));
      chk($sformatf("v_valid@%0d", cyc), 32'(V_VALID), 32'(e.vv));
      chk($sformatf("filled@%0d", cyc), 32'(FILLED), 32'(e.filled));
      chk($sformatf("spike_cnt@%0d", cyc), 32'(SPIKE_CNT), 32'(e.spk));
    end
  end
  task automatic model(input bit r, input bit c, input bit v, input logic [11:0] s, output exp_t e);
    int tot;
    e.vv = 1'b0;
    if (r || c) begin
      for (int i = 0; i < 16; i++) win[i] = '0;
      n = 0;
      m_vout = '0;
    end else if (v) begin
      for (int i = 0; i < 15; i++) win[i] = win[i+1];
      win[15] = s;
      n = (n < 16) ? n + 1 : 16;
      tot = 0;
      for (int i = 0; i < 16; i++) tot += int'(win[i]);
      m_vout = 12'(tot / 16);
      e.vv = (n == 16);
    end
    e.vout = m_vout;
    e.filled = (n == 16);
    e.spk = '0;
  endtask
  task automatic drive(input bit r, input bit c, input bit v, input logic [11:0] s, input exp_t e);
    @(negedge CLK);
    #1;
    RST = r;
    CLR = c;
    SAMPLE_VALID = v;
    SAMPLE_IN = s;
    exp_q.push_back(e);
  endtask
  task automatic mstep(input bit r, input bit c, input bit v, input logic [11:0] s);
    exp_t e;
    model(r, c, v, s, e);
    drive(r, c, v, s, e);
  endtask
  task automatic hstep(input bit c, input bit v, input logic [11:0] s, input int vout, input bit vv,
                       input bit f, input int spk);
    exp_t e;
    e.vout = 12'(vout);
    e.vv = vv;
    e.filled = f;
    e.spk = 8'(spk);
    drive(1'b0, c, v, s, e);
  endtask
  initial begin
    exp_t dummy;
    for (int k = 1; k <= 16; k++) begin
      tbl[k-1]  = '{1'b1, 1'b0, 12'd1000, '{12'((1000 * k) / 16), k == 16, k == 16, 8'd0}};
      tbl[k+15] = '{1'b1, 1'b0, 12'd4000, '{12'((1000 * (16 - k) + 4000 * k) / 16), 1'b1, 1'b1, 8'd0}};
      tbl[k+31] = '{1'b1, 1'b0, 12'd4095, '{12'((4000 * (16 - k) + 4095 * k) / 16), 1'b1, 1'b1, 8'd0}};
      tbl[k+47] = '{1'b1, 1'b0, 12'd0, '{12'((4095 * (16 - k)) / 16), 1'b1, 1'b1, 8'd0}};
    end
    mstep(1'b1, 1'b0, 1'b1, 12'd1234);
    mstep(1'b0, 1'b0, 1'b0, 12'd0);
`ifdef SPIKE_REJECT_EN
    for (int k = 1; k <= 16; k++) hstep(1'b0, 1'b1, 12'd2000, 125 * k, k == 16, k == 16, 0);
    hstep(1'b0, 1'b1, 12'd3000, 2000, 1'b1, 1'b1, 1);
    hstep(1'b0, 1'b1, 12'd2400, 2025, 1'b1, 1'b1, 1);
    hstep(1'b0, 1'b1, 12'd2625, 2026, 1'b1, 1'b1, 2);
    hstep(1'b0, 1'b0, 12'd0, 2026, 1'b0, 1'b1, 2);
    hstep(1'b1, 1'b1, 12'd2000, 0, 1'b0, 1'b0, 2);
    hstep(1'b0, 1'b1, 12'd4000, 250, 1'b0, 1'b0, 2);
`else
    for (int i = 0; i < 64; i++) begin
      model(1'b0, tbl[i].c, tbl[i].v, tbl[i].s, dummy);
      drive(1'b0, tbl[i].c, tbl[i].v, tbl[i].s, tbl[i].e);
    end
    for (int k = 0; k < 16; k++) mstep(1'b0, 1'b0, 1'b1, 12'd2000);
    mstep(1'b0, 1'b1, 1'b1, 12'd3000);
    for (int k = 0; k < 16; k++) mstep(1'b0, 1'b0, 1'b1, 12'd2500);
    mstep(1'b0, 1'b1, 1'b0, 12'd0);
    count_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mstep(1'b0, 1'b0, 1'b1, 12'($urandom_range(0, 4095)));
      for (int j = 0; j < 4; j++) mstep(1'b0, 1'b0, 1'b0, 12'($urandom_range(0, 4095)));
    end
    @(negedge CLK);
    count_en = 1'b0;
    chk("gap_pulses", 32'(pulses), 32'd25);
    for (int k = 0; k < 5; k++) mstep(1'b0, 1'b0, 1'b1, 12'(700 * k));
    mstep(1'b1, 1'b1, 1'b1, 12'd999);
    mstep(1'b0, 1'b0, 1'b1, 12'd1600);
`endif
    @(negedge CLK);
    @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/volt_window_filter.md
Name: volt_window_filter

Overview:
- Upstream conditioning stage for sp_optimizer.
- Takes raw 12-bit ADC voltage samples from the panel sense path with a valid strobe.
- Produces a boxcar moving average over a power-of-two window, so the optimizer's V_in comparisons are not driven by sample noise of up to ±2048 LSB.
- Output is registered and qualified by a one-cycle valid pulse.

Parameters:
LOG2_DEPTH, 4, log2 of window length D (D = 16 by default); legal range 1..6
SPIKE_THRESH, 512, absolute deviation in LSB above which a sample counts as a spike (used only with SPIKE_REJECT_EN)

Ports:
CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
CLR  input  1  synchronous window clear; same effect as RST on the filter state
SAMPLE_IN  input  12  raw ADC sample, unsigned
SAMPLE_VALID  input  1  SAMPLE_IN is valid this cycle; no backpressure, may be high every cycle
V_OUT  output  12  filtered voltage, feeds sp_optimizer V_in
V_VALID  output  1  one-cycle pulse: V_OUT updated
FILLED  output  1  high once D samples have been accepted since the last reset or clear
SPIKE_CNT  output  8  saturating count of rejected samples

Behaviour:
- Storage: D-entry x 12-bit register array, write pointer wr_ptr (LOG2_DEPTH bits), running sum (12+LOG2_DEPTH bits, unsigned), fill counter (LOG2_DEPTH+1 bits, saturates at D).
- Reset (RST=1 at an edge):
  - Clear all buffer entries, sum, wr_ptr and fill counter.
  - V_OUT=0, V_VALID=0, FILLED=0, SPIKE_CNT=0.
  - SAMPLE_VALID in the same cycle is ignored.
- CLR: identical clearing to RST in one cycle, except SPIKE_CNT is preserved.
  - CLR takes priority over a simultaneous SAMPLE_VALID; that sample is dropped.
  - RST has priority over CLR.
- Accepted sample s, at the edge where SAMPLE_VALID=1:
  - buf[wr_ptr] <= s
  - sum <= sum + s - buf[wr_ptr]
  - wr_ptr <= wr_ptr+1, wrapping from D-1 to 0
  - fill counter increments until it saturates at D.
- Output:
  - At the same edge, V_OUT <= (sum + s - buf[wr_ptr]) >> LOG2_DEPTH (floor, truncating). Latency is one cycle from sample to V_OUT.
  - V_VALID=1 in the cycle after an accepted sample, but only if the fill counter after that update equals D.
  - During fill, V_OUT still updates (partial average over zero-initialised entries) but V_VALID stays 0.
- FILLED:
  - Goes high the cycle after the D-th accepted sample.
  - Stays high until RST or CLR.
- Sum never overflows: max is D*4095, which fits 12+LOG2_DEPTH bits.
- Back-to-back valids every cycle are supported at full rate, with no bubbles.
- Idle cycles (SAMPLE_VALID=0): all state held, V_VALID=0.

Optional Feature:
- Macro: SPIKE_REJECT_EN.
- Defined:
  - When FILLED=1 and |s - V_OUT| > SPIKE_THRESH, the accepted sample is replaced by the current V_OUT before entering the buffer and sum.
  - SPIKE_CNT increments, saturating at 255.
  - V_VALID still pulses.
  - No rejection occurs while FILLED=0.
  - |s - V_OUT| is computed as a 13-bit signed difference.
- Not defined:
  - Every sample enters unchanged.
  - SPIKE_CNT is tied to 0.
  - SPIKE_THRESH is unused.

Test Plan:
- Fill: RST, then 16 consecutive cycles SAMPLE_VALID=1, SAMPLE_IN=1000 → V_VALID is 0 for the first 15 samples. In the cycle after the 16th: V_VALID=1, V_OUT=1000, FILLED=1.
- Step: after filling with 1000, feed 4000 each cycle → after k samples V_OUT=floor((1000*(16-k)+4000*k)/16), i.e. 1187 at k=1 and 2500 at k=8. After k=16, V_OUT=4000.
- Full-scale: 16 samples of 4095 → V_OUT=4095 and sum=65520, no wrap. Then 16 samples of 0 → V_OUT=0.
- Clear priority: filled at 2000, assert CLR and SAMPLE_VALID (3000) in the same cycle → next cycle FILLED=0, V_OUT=0, V_VALID=0, sample dropped. 16 fresh samples are needed before V_VALID returns.
- Gapped input: SAMPLE_VALID high one cycle in five, 40 samples → exactly 25 V_VALID pulses, each one cycle after its sample. V_OUT is held stable between pulses.
- Spike (SPIKE_REJECT_EN defined, SPIKE_THRESH=512): filled at 2000, sample 3000 → V_OUT stays 2000, SPIKE_CNT=1. Next sample 2400 → accepted, V_OUT=2025.
